modport_fifo: RTL and testbench
===============================

Name: modport_fifo

Overview:
- Synchronous circular-buffer FIFO for 8-bit data packets: write, read, undo (clear most recent write), and bypass (simultaneous write and read).
- Flags illegal command combinations and overflow/underflow on a registered `error` output.
- Sits between a packet producer and consumer on a single clock domain.

Parameters:
- DEPTH, 8, number of entries; must be a power of two, minimum 2.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- CLK  input  1  clock, rising edge.
- RESET  input  1  asynchronous, active-low reset.
- clear  input  1  undo: discard the most recently written, still-unread entry.
- rd_en  input  1  read request.
- wr_en  input  1  write request.
- wr_data  input  8 (data_packet_sp)  write data.
- rd_data  output  8 (data_packet_sp)  registered read data.
- fifo_empty  output  1  count == 0.
- fifo_full  output  1  count == DEPTH.
- error  output  1  registered illegal-operation flag.

Behaviour:
- Reset (RESET low, asynchronous): rd_ptr=0, wr_ptr=0, count=0, rd_data=0, error=0, so fifo_empty=1 and fifo_full=0. Storage contents are don't-care. All commands are ignored while RESET is low.
- fifo_empty and fifo_full are decoded combinationally from the registered count.
- Commands are sampled at the rising CLK edge and decoded from {wr_en, rd_en, clear}:
  - 000 idle: nothing changes; error<=0.
  - 100 write: if not full, mem[wr_ptr]<=wr_data, wr_ptr++, count++. If full, no state change and error<=1.
  - 010 read: if not empty, rd_data<=mem[rd_ptr], rd_ptr++, count--. If empty, rd_data holds and error<=1.
  - 001 undo: if not empty, wr_ptr--, count--, and the entry is discarded. If empty, error<=1.
  - 110 bypass, FIFO empty: rd_data<=wr_data; pointers and count unchanged.
  - 110 bypass, FIFO not empty: rd_data<=mem[rd_ptr]; wr_data is written at wr_ptr; both pointers advance; count unchanged. This applies even when full.
  - Any code with clear=1 plus wr_en or rd_en (101, 011, 111): no state change; error<=1.
- Pointers wrap modulo DEPTH; the undo decrement also wraps (0 -> DEPTH-1).
- rd_data holds its last value on every non-read cycle.
- error is a one-cycle pulse: high in the cycle after the offending command, cleared by the next legal command or idle.
- Latency: read data and flags are valid one cycle after the command edge.
- Reset mid-operation: all state clears immediately, with no pending write committed.

Optional Feature:
- Macro: MODPORT_FIFO_STICKY_ERROR_EN.
- Defined: error, once set, stays 1 until RESET is asserted; commands continue to execute normally.
- Undefined: error is the one-cycle pulse described above.

Decomposition:
- Package dataTypes holds:
  - typedef data_packet_sp: packed 8-bit logic.
  - constant DEFAULT_DEPTH=8.
  - enum cmd_e for the {wr,rd,clear} codes.
- One natural sub-module, modport_fifo_mem: DEPTH x 8 register array with synchronous write port and combinational read port at the given index. The control, pointer and count logic stays in the top module.

Test Plan:
- Reset for 5 cycles with wr/rd/clear=111 held -> after release: fifo_empty=1, fifo_full=0, error=0, rd_data=0.
- Write 0x11,0x22,0x33, then read x3 -> rd_data sequence 0x11,0x22,0x33; fifo_empty=1 after the last read.
- Write 8 values 0x01..0x08, then write 0x09 -> fifo_full=1, error pulse, count stays 8. Read x8 -> 0x01..0x08, showing wrap-around.
- Write 0xA0,0xB0, undo, then read x2 -> first read 0xA0; second read asserts error (empty).
- Bypass 0x5A on empty -> rd_data=0x5A, fifo_empty stays 1. Write 0x10, then bypass 0x20 -> rd_data=0x10; a following read gives 0x20.
- Write_clear 0x77 on empty -> error=1, fifo_empty=1. Read on empty -> error=1. Undo on empty -> error=1.

Source files
------------

// File: rtl/modport_fifo_pkg.sv
// Shared types for the modport_fifo slice: packet type, default depth and command encoding.
package dataTypes;

    typedef logic [7:0] data_packet_sp;

    localparam int DEFAULT_DEPTH = 8;

    // Command code is {wr_en, rd_en, clear}
    typedef enum logic [2:0] {
        CMD_IDLE     = 3'b000,
        CMD_UNDO     = 3'b001,
        CMD_READ     = 3'b010,
        CMD_RD_CLEAR = 3'b011,
        CMD_WRITE    = 3'b100,
        CMD_WR_CLEAR = 3'b101,
        CMD_BYPASS   = 3'b110,
        CMD_ALL      = 3'b111
    } cmd_e;

endpackage

// File: rtl/modport_fifo_if.sv
// Producer/consumer handshake bundle for modport_fifo; master drives commands, slave is the FIFO.
interface modport_fifo_if;
  import dataTypes::*;

  logic          clear;
  logic          rd_en;
  logic          wr_en;
  data_packet_sp wr_data;
  data_packet_sp rd_data;
  logic          fifo_empty;
  logic          fifo_full;
  logic          error;

  modport master (
    output clear, rd_en, wr_en, wr_data,
    input  rd_data, fifo_empty, fifo_full, error
  );

  modport slave (
    input  clear, rd_en, wr_en, wr_data,
    output rd_data, fifo_empty, fifo_full, error
  );

endinterface

// File: rtl/modport_fifo_mem.sv
// DEPTH x 8 storage array: synchronous write port, combinational read port.
module modport_fifo_mem
  import dataTypes::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  data_packet_sp    wdata,
  input  logic [PTR_W-1:0] raddr,
  output data_packet_sp    rdata
);

  data_packet_sp mem_r [DEPTH];

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/modport_fifo.sv
// Circular-buffer FIFO with write/read/undo/bypass commands and a registered error flag.
// Define MODPORT_FIFO_STICKY_ERROR_EN to make error latch until RESET.
module modport_fifo
  import dataTypes::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input logic           CLK,
  input logic           RESET,
  modport_fifo_if.slave bus
);

  cmd_e             cmd_s;
  logic [PTR_W-1:0] rd_ptr_r, rd_ptr_s;
  logic [PTR_W-1:0] wr_ptr_r, wr_ptr_s;
  logic [CNT_W-1:0] count_r, count_s;
  data_packet_sp    rd_data_r, rd_data_s;
  data_packet_sp    mem_rdata_s;
  logic             error_r, error_s;
  logic             err_cmd_s;
  logic             mem_we_s;
  logic             empty_s;
  logic             full_s;

  assign empty_s = (count_r == {CNT_W{1'b0}});
  assign full_s  = (count_r == CNT_W'(DEPTH));
  assign cmd_s   = cmd_e'({bus.wr_en, bus.rd_en, bus.clear});

  modport_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .CLK   (CLK),
    .we    (mem_we_s),
    .waddr (wr_ptr_r),
    .wdata (bus.wr_data),
    .raddr (rd_ptr_r),
    .rdata (mem_rdata_s)
  );

  // Command decode: next pointers, count, read data and error condition.
  always_comb begin
    rd_ptr_s  = rd_ptr_r;
    wr_ptr_s  = wr_ptr_r;
    count_s   = count_r;
    rd_data_s = rd_data_r;
    err_cmd_s = 1'b0;
    mem_we_s  = 1'b0;
    case (cmd_s)
      CMD_IDLE: begin
        err_cmd_s = 1'b0;
      end
      CMD_WRITE: begin
        if (full_s) begin
          err_cmd_s = 1'b1;
        end else begin
          mem_we_s = 1'b1;
          wr_ptr_s = wr_ptr_r + PTR_W'(1'b1);
          count_s  = count_r + CNT_W'(1'b1);
        end
      end
      CMD_READ: begin
        if (empty_s) begin
          err_cmd_s = 1'b1;
        end else begin
          rd_data_s = mem_rdata_s;
          rd_ptr_s  = rd_ptr_r + PTR_W'(1'b1);
          count_s   = count_r - CNT_W'(1'b1);
        end
      end
      CMD_UNDO: begin
        if (empty_s) begin
          err_cmd_s = 1'b1;
        end else begin
          wr_ptr_s = wr_ptr_r - PTR_W'(1'b1);
          count_s  = count_r - CNT_W'(1'b1);
        end
      end
      CMD_BYPASS: begin
        // When full, rd_ptr == wr_ptr: the slot is read before it is overwritten.
        if (empty_s) begin
          rd_data_s = bus.wr_data;
        end else begin
          rd_data_s = mem_rdata_s;
          mem_we_s  = 1'b1;
          rd_ptr_s  = rd_ptr_r + PTR_W'(1'b1);
          wr_ptr_s  = wr_ptr_r + PTR_W'(1'b1);
        end
      end
      default: begin
        err_cmd_s = 1'b1;
      end
    endcase
`ifdef MODPORT_FIFO_STICKY_ERROR_EN
    error_s = error_r | err_cmd_s;
`else
    error_s = err_cmd_s;
`endif
  end

  // Control state registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rd_ptr_r  <= {PTR_W{1'b0}};
      wr_ptr_r  <= {PTR_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      rd_data_r <= 8'h00;
      error_r   <= 1'b0;
    end else begin
      rd_ptr_r  <= rd_ptr_s;
      wr_ptr_r  <= wr_ptr_s;
      count_r   <= count_s;
      rd_data_r <= rd_data_s;
      error_r   <= error_s;
    end
  end

  assign bus.rd_data    = rd_data_r;
  assign bus.error      = error_r;
  assign bus.fifo_empty = empty_s;
  assign bus.fifo_full  = full_s;

endmodule

// File: tb/tb_modport_fifo.sv
// Directed self-checking bench for modport_fifo (default depth 8).
module tb_modport_fifo;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;
  logic err_seen;

  modport_fifo_if bus_if ();

  modport_fifo dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Error expectation accounts for the sticky build, where error latches until reset.
  task automatic check_err(input string tag, input logic pulse);
    logic exp;
    if (pulse) err_seen = 1'b1;
`ifdef MODPORT_FIFO_STICKY_ERROR_EN
    exp = err_seen;
`else
    exp = pulse;
`endif
    check(tag, {7'd0, bus_if.error}, {7'd0, exp});
  endtask

  task automatic cmd(input logic w, input logic r, input logic c, input logic [7:0] d);
    bus_if.wr_en   = w;
    bus_if.rd_en   = r;
    bus_if.clear   = c;
    bus_if.wr_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);   cmd(1'b1, 1'b0, 1'b0, d);     endtask
  task automatic rd();                      cmd(1'b0, 1'b1, 1'b0, 8'h00); endtask
  task automatic undo();                    cmd(1'b0, 1'b0, 1'b1, 8'h00); endtask
  task automatic idle();                    cmd(1'b0, 1'b0, 1'b0, 8'h00); endtask
  task automatic bypass(input logic [7:0] d); cmd(1'b1, 1'b1, 1'b0, d);   endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    err_seen     = 1'b0;

    // Reset with all commands asserted; they must be ignored.
    rst_n = 1'b0;
    bus_if.wr_en = 1'b1; bus_if.rd_en = 1'b1; bus_if.clear = 1'b1; bus_if.wr_data = 8'hFF;
    repeat (5) @(posedge clk);
    #1;
    check("rst_empty_in_reset", {7'd0, bus_if.fifo_empty}, 8'h01);
    rst_n = 1'b1;
    idle();
    check("rst_empty", {7'd0, bus_if.fifo_empty}, 8'h01);
    check("rst_full", {7'd0, bus_if.fifo_full}, 8'h00);
    check_err("rst_error", 1'b0);
    check("rst_rd_data", bus_if.rd_data, 8'h00);

    // Basic write then read ordering.
    wr(8'h11);
    check("w1_empty", {7'd0, bus_if.fifo_empty}, 8'h00);
    wr(8'h22);
    wr(8'h33);
    check_err("w3_error", 1'b0);
    rd(); check("r1_data", bus_if.rd_data, 8'h11);
    rd(); check("r2_data", bus_if.rd_data, 8'h22);
    rd(); check("r3_data", bus_if.rd_data, 8'h33);
    check("r3_empty", {7'd0, bus_if.fifo_empty}, 8'h01);

    // Fill to DEPTH across the pointer wrap, then overflow.
    for (int i = 1; i <= 8; i++) wr(8'(i));
    check("fill_full", {7'd0, bus_if.fifo_full}, 8'h01);
    check_err("fill_error", 1'b0);
    wr(8'h09);
    check_err("ovf_error", 1'b1);
    check("ovf_full", {7'd0, bus_if.fifo_full}, 8'h01);
    idle();
    check_err("ovf_clear", 1'b0);
    for (int i = 1; i <= 8; i++) begin
      rd();
      check($sformatf("wrap_rd%0d", i), bus_if.rd_data, 8'(i));
    end
    check("wrap_empty", {7'd0, bus_if.fifo_empty}, 8'h01);

    // Undo discards the most recent write.
    wr(8'hA0);
    wr(8'hB0);
    undo();
    check_err("undo_error", 1'b0);
    rd(); check("undo_rd", bus_if.rd_data, 8'hA0);
    check("undo_empty", {7'd0, bus_if.fifo_empty}, 8'h01);
    rd();
    check_err("udf_error", 1'b1);
    check("udf_hold", bus_if.rd_data, 8'hA0);

    // Bypass on empty and non-empty FIFO.
    bypass(8'h5A);
    check("byp_e_data", bus_if.rd_data, 8'h5A);
    check("byp_e_empty", {7'd0, bus_if.fifo_empty}, 8'h01);
    check_err("byp_e_error", 1'b0);
    wr(8'h10);
    bypass(8'h20);
    check("byp_ne_data", bus_if.rd_data, 8'h10);
    check("byp_ne_empty", {7'd0, bus_if.fifo_empty}, 8'h00);
    rd(); check("byp_ne_rd", bus_if.rd_data, 8'h20);
    check("byp_ne_empty2", {7'd0, bus_if.fifo_empty}, 8'h01);

    // Illegal combinations and empty-FIFO errors.
    cmd(1'b1, 1'b0, 1'b1, 8'h77);
    check_err("wclr_error", 1'b1);
    check("wclr_empty", {7'd0, bus_if.fifo_empty}, 8'h01);
    cmd(1'b0, 1'b1, 1'b1, 8'h00);
    check_err("rclr_error", 1'b1);
    idle();
    check_err("idle_clear", 1'b0);
    rd();
    check_err("rd_empty_error", 1'b1);
    check("rd_empty_hold", bus_if.rd_data, 8'h20);
    undo();
    check_err("undo_empty_error", 1'b1);

    // Bypass while full keeps count at DEPTH.
    for (int i = 0; i < 8; i++) wr(8'hC1 + 8'(i));
    bypass(8'hD0);
    check("byp_f_data", bus_if.rd_data, 8'hC1);
    check("byp_f_full", {7'd0, bus_if.fifo_full}, 8'h01);
    check_err("byp_f_error", 1'b0);
    for (int i = 0; i < 7; i++) begin
      rd();
      check($sformatf("byp_f_rd%0d", i), bus_if.rd_data, 8'hC2 + 8'(i));
    end
    rd(); check("byp_f_last", bus_if.rd_data, 8'hD0);
    check("byp_f_empty", {7'd0, bus_if.fifo_empty}, 8'h01);

    // Write pointer now sits at 7: write wraps it to 0, undo must wrap back to 7.
    wr(8'hE1);
    undo();
    check("uwrap_empty", {7'd0, bus_if.fifo_empty}, 8'h01);
    wr(8'hE2);
    rd(); check("uwrap_rd", bus_if.rd_data, 8'hE2);

    // Asynchronous reset mid-operation with a write pending.
    wr(8'hF0);
    bus_if.wr_en = 1'b1; bus_if.wr_data = 8'hF1;
    #2;
    rst_n = 1'b0;
    err_seen = 1'b0;
    #1;
    check("mid_rst_empty", {7'd0, bus_if.fifo_empty}, 8'h01);
    check("mid_rst_rd_data", bus_if.rd_data, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    check("mid_rst_empty2", {7'd0, bus_if.fifo_empty}, 8'h01);
    rd();
    check_err("mid_rst_rd_err", 1'b1);
    check("mid_rst_rd_hold", bus_if.rd_data, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
